// File: rtl/tt_ctrl_seq.sv
// Mux control sequencer: selects a design by counting the selector,
// then enables it and runs a user-module reset of programmable length.
module tt_ctrl_seq #(
  parameter int ADDR_W         = 10,
  parameter int SEL_RST_CYCLES = 2,
  parameter int UM_RST_CYCLES  = 8
) (
  input  logic              clk_a,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              disable_i,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              um_rst_n,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              done
);

  localparam int CMAX = (SEL_RST_CYCLES > UM_RST_CYCLES) ?
                        SEL_RST_CYCLES : UM_RST_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SRST, INC_HI, INC_LO, UMRST, RUN
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_rst_n_q, sel_rst_n_d;
  logic inc_q, inc_d;
  logic ena_q, ena_d;
  logic um_q, um_d;
  logic done_q, done_d;
  logic rdy_q, rdy_d;
  logic step;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    sel_rst_n_d = 1'b1;
    inc_d       = 1'b0;
    ena_d       = ena_q;
    um_d        = um_q;
    done_d      = 1'b0;
    step        = 1'b0;
    if (disable_i) begin
      state_d = IDLE;
      ena_d   = 1'b0;
      um_d    = 1'b0;
      // a pulse in flight still reaches the external counter
      if (state_q == INC_HI) cur_d = cur_q + 1'b1;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (req_valid) begin
            tgt_d = req_addr;
            ena_d = 1'b0;
            um_d  = 1'b0;
            if (req_addr >= cur_q) begin
              state_d = INC_LO;
            end else begin
              state_d = SRST;
              cur_d   = '0;
              cnt_d   = CNT_W'(SEL_RST_CYCLES);
            end
          end
        end
        SRST: begin
          if (cnt_q != '0) begin
            sel_rst_n_d = 1'b0;
            cnt_d       = cnt_q - 1'b1;
          end else begin
            step = 1'b1;
          end
        end
        INC_LO: step = 1'b1;
        INC_HI: begin
          cur_d   = cur_q + 1'b1;
          state_d = INC_LO;
        end
        UMRST: begin
          if (cnt_q == '0) begin
            um_d    = 1'b1;
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (step) begin
        if (cur_q == tgt_q) begin
          state_d = UMRST;
          ena_d   = 1'b1;
          cnt_d   = CNT_W'(UM_RST_CYCLES - 1);
        end else begin
          state_d = INC_HI;
          inc_d   = 1'b1;
        end
      end
    end
    rdy_d = (state_d == IDLE) || (state_d == RUN);
  end

  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      sel_rst_n_q <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      um_q        <= 1'b0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      sel_rst_n_q <= sel_rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
      um_q        <= um_d;
      done_q      <= done_d;
      rdy_q       <= rdy_d;
    end
  end

  assign req_ready      = rdy_q;
  assign busy           = ~rdy_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;
  assign um_rst_n       = um_q;
  assign cur_addr       = cur_q;
  assign done           = done_q;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Directed bench for tt_ctrl_seq: selection, reselect, user reset,
// abort by disable and by rst_n.
module tb_tt_ctrl_seq;

  logic       clk_a = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       disable_i;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;
  logic       um_rst_n;
  logic [9:0] cur_addr;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  tt_ctrl_seq #(
    .ADDR_W(10), .SEL_RST_CYCLES(2), .UM_RST_CYCLES(8)
  ) dut (
    .clk_a(clk_a), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .disable_i(disable_i),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena), .um_rst_n(um_rst_n),
    .cur_addr(cur_addr), .busy(busy), .done(done)
  );

  always #5 clk_a = ~clk_a;

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int np, nsr, sr_first, sr_last, ena_at, um_at, done_at, b2b;

  // accept at edge k (index 0), then profile edges k+1.. until done
  task automatic run_req(input logic [9:0] a, input int maxc);
    logic prev_inc;
    np = 0; nsr = 0; sr_first = -1; sr_last = -1;
    ena_at = -1; um_at = -1; done_at = -1; b2b = 0;
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = 10'h3ff;
    chk("accept_ena_low", int'(ctrl_ena), 0);
    chk("accept_um_low", int'(um_rst_n), 0);
    prev_inc = ctrl_sel_inc;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (ctrl_sel_inc) np++;
      if (ctrl_sel_inc && prev_inc) b2b++;
      prev_inc = ctrl_sel_inc;
      if (!ctrl_sel_rst_n) begin
        nsr++;
        if (sr_first < 0) sr_first = i;
        sr_last = i;
      end
      if (ctrl_ena && ena_at < 0) ena_at = i;
      if (um_rst_n && um_at < 0) um_at = i;
      if (done) begin
        done_at = i;
        break;
      end
    end
    chk("pulse_spacing", b2b, 0);
  endtask

  initial begin
    int cnt;
    int seen_done;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; disable_i = 1'b0;
    tick();
    tick();
    chk("rst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
    chk("rst_inc", int'(ctrl_sel_inc), 0);
    chk("rst_ena", int'(ctrl_ena), 0);
    chk("rst_um", int'(um_rst_n), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_cur", int'(cur_addr), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_sel_rst_n", int'(ctrl_sel_rst_n), 1);

    // 0 -> 0x180
    run_req(10'h180, 2000);
    chk("t1_pulses", np, 384);
    chk("t1_srst", nsr, 0);
    chk("t1_ena_at", ena_at, 769);
    chk("t1_um_at", um_at, 777);
    chk("t1_done_at", done_at, 777);
    chk("t1_cur", int'(cur_addr), 384);
    chk("t1_ready", int'(req_ready), 1);
    tick();
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_run_ena", int'(ctrl_ena), 1);
    chk("t1_run_um", int'(um_rst_n), 1);

    // 384 -> 386
    run_req(10'd386, 200);
    chk("t2_pulses", np, 2);
    chk("t2_ena_at", ena_at, 5);
    chk("t2_um_at", um_at, 13);
    chk("t2_cur", int'(cur_addr), 386);

    // 386 -> 3 goes backwards through selector reset
    run_req(10'd3, 200);
    chk("t3_srst_n", nsr, 2);
    chk("t3_srst_first", sr_first, 1);
    chk("t3_srst_last", sr_last, 2);
    chk("t3_pulses", np, 3);
    chk("t3_ena_at", ena_at, 9);
    chk("t3_cur", int'(cur_addr), 3);

    // same address: pure user reset
    run_req(10'd3, 200);
    chk("t4_pulses", np, 0);
    chk("t4_ena_at", ena_at, 1);
    chk("t4_um_at", um_at, 9);
    chk("t4_done_at", done_at, 9);

    // back to 0 via rst_n, then 0 -> 20 aborted on 10th pulse
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_addr = 10'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ctrl_sel_inc) cnt++;
      if (cnt == 10) break;
    end
    chk("t5_reach_10th", cnt, 10);
    disable_i = 1'b1;
    tick();
    disable_i = 1'b0;
    chk("t5_ena", int'(ctrl_ena), 0);
    chk("t5_inc", int'(ctrl_sel_inc), 0);
    chk("t5_um", int'(um_rst_n), 0);
    chk("t5_cur", int'(cur_addr), 10);
    chk("t5_ready", int'(req_ready), 1);
    chk("t5_busy", int'(busy), 0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || ctrl_sel_inc) seen_done++;
    end
    chk("t5_no_done", seen_done, 0);
    run_req(10'd12, 200);
    chk("t5_pulses", np, 2);
    chk("t5_done_at", done_at, 13);
    chk("t5_cur12", int'(cur_addr), 12);

    // rst_n mid-INC on the way 12 -> 20
    req_addr = 10'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_sel_rst_n", int'(ctrl_sel_rst_n), 0);
    chk("t6_inc", int'(ctrl_sel_inc), 0);
    chk("t6_ena", int'(ctrl_ena), 0);
    chk("t6_um", int'(um_rst_n), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ready", int'(req_ready), 1);
    chk("t6_cur", int'(cur_addr), 0);
    rst_n = 1'b1;
    tick();
    run_req(10'd5, 200);
    chk("t6_pulses", np, 5);
    chk("t6_srst", nsr, 0);
    chk("t6_ena_at", ena_at, 11);
    chk("t6_done_at", done_at, 19);
    chk("t6_cur", int'(cur_addr), 5);

    // disable and request together: request dropped
    req_addr = 10'd9; req_valid = 1'b1; disable_i = 1'b1;
    tick();
    req_valid = 1'b0; disable_i = 1'b0;
    chk("t7_ena", int'(ctrl_ena), 0);
    chk("t7_ready", int'(req_ready), 1);
    chk("t7_busy", int'(busy), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ctrl_sel_inc || busy) cnt++;
    end
    chk("t7_idle", cnt, 0);
    chk("t7_cur", int'(cur_addr), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_ctrl_seq.md
Name: tt_ctrl_seq

Overview:
- Synthesisable sequencer for the mux control interface: ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.
- Takes a requested design address through a valid/ready port and selects that design by counting. It counts forward from the current address when it can, otherwise resets the selector and counts from 0.
- After selection it enables the design and runs a user-module reset of programmable length.
- Replaces hard-coded per-bench selection logic. Used by the top-level harness and the board-side controller.

Parameters:
- ADDR_W, 10: address width, {mux_id, blk_id}.
- SEL_RST_CYCLES, 2: cycles ctrl_sel_rst_n is held low when the address must go backwards (≥1).
- UM_RST_CYCLES, 8: cycles um_rst_n is held low after ctrl_ena rises (≥1).

Ports:
- clk_a  in  1  clock, shared with the selector counter.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  selection request.
- req_ready  out  1  high in IDLE and RUN only.
- req_addr  in  ADDR_W  target design address.
- disable  in  1  one-cycle pulse; drop enable and go to IDLE.
- ctrl_sel_rst_n  out  1  selector counter reset, active-low.
- ctrl_sel_inc  out  1  selector increment strobe.
- ctrl_ena  out  1  design enable.
- um_rst_n  out  1  user-module reset, active-low.
- cur_addr  out  ADDR_W  shadow of the selector counter.
- busy  out  1  high in any state other than IDLE and RUN.
- done  out  1  one-cycle pulse when um_rst_n is released.

Behaviour:
- All outputs are registered. States: IDLE, SRST, INC_HI, INC_LO, UMRST, RUN.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; cur_addr=0.
  - ctrl_sel_rst_n=0 while rst_n is low, then 1. The external counter is reset alongside, so cur_addr=0 stays coherent.
  - ctrl_sel_inc=0, ctrl_ena=0, um_rst_n=0, done=0, busy=0, req_ready=1.
- Accept: req_valid & req_ready sampled at edge k.
  - Latch the target; drive ctrl_ena=0 and um_rst_n=0 from edge k.
  - If target ≥ cur_addr, go to INC_LO, counting D = target - cur_addr.
  - Otherwise go to SRST, counting D = target.
- SRST:
  - ctrl_sel_rst_n=0 for SEL_RST_CYCLES cycles, starting at edge k+1.
  - cur_addr is set to 0 on entry.
  - Then behaves like INC_LO, starting at edge k+1+SEL_RST_CYCLES.
- INC_LO: if cur_addr == target, go to UMRST. Otherwise go to INC_HI.
- INC_HI:
  - ctrl_sel_inc=1 for exactly one cycle, then go to INC_LO.
  - cur_addr increments (modulo 2^ADDR_W) on the edge that ends the pulse.
  - Consecutive pulses are always separated by ≥1 low cycle.
- Forward timing:
  - Pulses go high at edges k+1, k+3, …, k+2D-1.
  - ctrl_ena=1 from edge k+2D+1.
  - D=0 gives ctrl_ena at k+1; a same-address request acts as a pure user reset.
- Backward timing: ctrl_ena=1 from edge k+SEL_RST_CYCLES+2D+1.
- UMRST:
  - ctrl_ena=1 and um_rst_n=0 for UM_RST_CYCLES cycles.
  - um_rst_n=1 and done=1 on the following edge, then go to RUN.
- RUN:
  - ctrl_ena=1, um_rst_n=1, req_ready=1.
  - A new accepted request restarts the flow above.
- disable:
  - Accepted in any state. ctrl_ena=0, ctrl_sel_inc=0, um_rst_n=0 and state=IDLE from the next edge.
  - A pulse already high during the cycle counts; cur_addr includes it.
  - disable and req_valid at the same edge: disable wins and the request is not accepted.
- done never asserts on an aborted sequence.
- req_addr is sampled only at accept; changes while busy are ignored.

Test Plan:
- Reset, then request 0x180 (mux 12, blk 0):
  - 384 inc pulses, no ctrl_sel_rst_n low.
  - ctrl_ena rises at k+769; um_rst_n and done at k+777; cur_addr=384.
- From RUN at 384, request 386:
  - 2 pulses; ctrl_ena drops at k and rises at k+5; um_rst_n high at k+13.
- From 386, request 3:
  - ctrl_sel_rst_n low at edges k+1..k+2, then 3 pulses.
  - ctrl_ena at k+9; cur_addr=3.
- Request 3 again while at 3:
  - no pulses; ctrl_ena low one cycle, high from k+1.
  - um_rst_n low 8 cycles; done at k+9.
- disable during the 10th pulse of a 0→20 request:
  - IDLE next edge with ctrl_ena=0 and cur_addr=10; no done.
  - A following request for 12 gives 2 pulses.
- rst_n low mid-INC: all outputs take their reset values at the next edge; cur_addr=0; a subsequent request for 5 gives 5 pulses.
